mm_ctrl: RTL and testbench
==========================

MM_CTRL -- requirements
Module: mm_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a 4x4 matrix multiply.
REQ-004 SHALL have port: abort  input  1  synchronous cancel of any operation in progress.
REQ-005 SHALL have ports: in_valid input 1, in_ready output 1, in_data input 8  operand byte stream.
REQ-006 SHALL have ports: ireg_write output 1, ireg_addr_in output 5, ireg_data_in output 8  register-file write port.
REQ-007 SHALL have ports: ireg_addr_out_1..4 output 5 each, ireg_data_out_1..4 input 8 each  register-file read ports (combinational read).
REQ-008 SHALL have ports: out_valid output 1, out_ready input 1, out_data output 18, out_idx output 4  result stream.
REQ-009 SHALL have ports: busy output 1, done output 1  status; done is a one-cycle pulse.

Function
REQ-010 SHALL implement states IDLE, LOAD, COMPUTE, OUT, DONE.
REQ-011 SHALL move IDLE->LOAD on start=1; start SHALL be ignored in every other state.
REQ-012 SHALL assert in_ready=1 only in LOAD; a byte is accepted when in_valid&&in_ready.
REQ-013 SHALL, on each accepted byte, drive ireg_write=1, ireg_addr_in=load count (0..31), ireg_data_in=in_data in the same cycle; ireg_write=0 otherwise.
REQ-014 SHALL map A[i][k] to address 4i+k and B[k][j] to 16+4k+j; byte order is A row-major then B row-major.
REQ-015 SHALL move LOAD->COMPUTE in the cycle after the 32nd byte is accepted; load count SHALL not wrap.
REQ-016 SHALL compute element e (0..15), i=e[3:2], j=e[1:0], in two COMPUTE cycles p=0,1.
REQ-017 SHALL drive in phase p: addr_out_1=4i+2p, addr_out_2=4i+2p+1, addr_out_3=16+8p+j, addr_out_4=16+8p+4+j.
REQ-018 SHALL accumulate acc <= (p==0 ? 0 : acc) + d1*d3 + d2*d4 at 18-bit width, no saturation.
REQ-019 SHALL, after p=1, enter OUT with out_valid=1, out_data=acc, out_idx=e, all held stable until out_ready=1.
REQ-020 SHALL, on out_valid&&out_ready, go to COMPUTE for e+1, or to DONE when e=15.
REQ-021 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle, clearing counters, out_valid and in_ready; no done pulse. abort has priority over all handshakes in the same cycle.
REQ-024 SHALL drive read addresses to 0 outside COMPUTE.
REQ-025 SHALL give latency start->first out_valid of 32 accepted bytes + 3 cycles with no stalls.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, all counters and acc to 0, and in_ready, out_valid, out_data, out_idx, busy, done, ireg_write to 0, independent of clk.
REQ-027 SHALL, on reset assertion mid-operation, discard all progress; a new start is required after release.

Configuration
REQ-028 SHALL support macro MM_CTRL_SIGNED_EN.
REQ-029 SHALL, when MM_CTRL_SIGNED_EN is defined, treat operands as two's-complement signed 8-bit and out_data as signed 18-bit.
REQ-030 SHALL, when MM_CTRL_SIGNED_EN is undefined, treat operands and out_data as unsigned.

Verification
REQ-031 SHALL cover: A=identity, B[k][j]=4k+j+1 -> out_data sequence 1..16, out_idx 0..15, then one done pulse.
REQ-032 SHALL cover (unsigned build): all 32 bytes 0xFF -> every out_data=260100.
REQ-033 SHALL cover (signed build): all bytes 0x80 -> every out_data=65536; A all 0x80, B all 0x7F -> every out_data=-65024.
REQ-034 SHALL cover: out_ready low 5 cycles on element 3 -> out_valid, out_data, out_idx=3 held unchanged, no extra element emitted.
REQ-035 SHALL cover: abort after 10 bytes loaded -> IDLE next cycle, busy=0, no done; start during busy ignored; in_valid gaps delay only LOAD.
REQ-036 SHALL cover: rst_n pulsed low mid-COMPUTE with no clk edge -> all outputs 0 immediately.

Source files
------------

// File: rtl/mm_ctrl.sv
// 4x4 byte-matrix multiply sequencer: streams 32 operand bytes into an external register file, then emits 16 dot products.
// Build option: define MM_CTRL_SIGNED_EN for two's-complement operands and a signed 18-bit result (default is unsigned).
module mm_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        ireg_write,
  output logic [4:0]  ireg_addr_in,
  output logic [7:0]  ireg_data_in,
  output logic [4:0]  ireg_addr_out_1,
  output logic [4:0]  ireg_addr_out_2,
  output logic [4:0]  ireg_addr_out_3,
  output logic [4:0]  ireg_addr_out_4,
  input  logic [7:0]  ireg_data_out_1,
  input  logic [7:0]  ireg_data_out_2,
  input  logic [7:0]  ireg_data_out_3,
  input  logic [7:0]  ireg_data_out_4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT, S_DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  load_cnt;
  logic [3:0]  elem;
  logic        phase;
  logic [17:0] acc;
  logic [17:0] term;
  logic        accept;

  // Sign or zero extension to the accumulator width; the low 18 bits of the
  // product are then identical for both interpretations.
  function automatic logic [17:0] ext(input logic [7:0] d);
`ifdef MM_CTRL_SIGNED_EN
    return {{10{d[7]}}, d};
`else
    return {10'd0, d};
`endif
  endfunction

  assign accept = (state == S_LOAD) && in_valid && !abort;
  assign term   = ext(ireg_data_out_1) * ext(ireg_data_out_3)
                + ext(ireg_data_out_2) * ext(ireg_data_out_4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_next = S_LOAD;
        S_LOAD:    if (accept && load_cnt == 5'd31) state_next = S_COMPUTE;
        S_COMPUTE: if (phase) state_next = S_OUT;
        S_OUT:     if (out_ready) state_next = (elem == 4'd15) ? S_DONE : S_COMPUTE;
        S_DONE:    state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready        = (state == S_LOAD);
    ireg_write      = accept;
    ireg_addr_in    = load_cnt;
    ireg_data_in    = accept ? in_data : 8'd0;
    out_valid       = (state == S_OUT);
    out_data        = acc;
    out_idx         = elem;
    busy            = (state != S_IDLE);
    done            = (state == S_DONE) && !abort;
    ireg_addr_out_1 = 5'd0;
    ireg_addr_out_2 = 5'd0;
    ireg_addr_out_3 = 5'd0;
    ireg_addr_out_4 = 5'd0;
    if (state == S_COMPUTE) begin
      // A row i, columns 2p and 2p+1; B rows 2p and 2p+1, column j.
      ireg_addr_out_1 = {1'b0, elem[3:2], phase, 1'b0};
      ireg_addr_out_2 = {1'b0, elem[3:2], phase, 1'b1};
      ireg_addr_out_3 = {1'b1, phase, 1'b0, elem[1:0]};
      ireg_addr_out_4 = {1'b1, phase, 1'b1, elem[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= 5'd0;
      elem     <= 4'd0;
      phase    <= 1'b0;
      acc      <= 18'd0;
    end else if (abort && state != S_IDLE) begin
      load_cnt <= 5'd0;
      elem     <= 4'd0;
      phase    <= 1'b0;
      acc      <= 18'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load_cnt <= 5'd0;
            elem     <= 4'd0;
            phase    <= 1'b0;
            acc      <= 18'd0;
          end
        end
        S_LOAD: begin
          // Hold at 31 after the last byte; the next start clears it.
          if (accept && load_cnt != 5'd31) load_cnt <= load_cnt + 5'd1;
        end
        S_COMPUTE: begin
          acc   <= (phase ? acc : 18'd0) + term;
          phase <= ~phase;
        end
        S_OUT: begin
          if (out_ready) elem <= elem + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_ctrl.sv
// Directed bench for mm_ctrl with a behavioural 32x8 register file attached to its write/read ports.
module tb_mm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        ireg_write;
  logic [4:0]  ireg_addr_in;
  logic [7:0]  ireg_data_in;
  logic [4:0]  ireg_addr_out_1, ireg_addr_out_2, ireg_addr_out_3, ireg_addr_out_4;
  logic [7:0]  ireg_data_out_1, ireg_data_out_2, ireg_data_out_3, ireg_data_out_4;
  logic        out_valid, out_ready;
  logic [17:0] out_data;
  logic [3:0]  out_idx;
  logic        busy, done;

  logic [7:0]  rf [32];
  logic [7:0]  bytes [32];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          first_valid_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ireg_write) rf[ireg_addr_in] <= ireg_data_in;

  assign ireg_data_out_1 = rf[ireg_addr_out_1];
  assign ireg_data_out_2 = rf[ireg_addr_out_2];
  assign ireg_data_out_3 = rf[ireg_addr_out_3];
  assign ireg_data_out_4 = rf[ireg_addr_out_4];

  mm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ireg_write(ireg_write), .ireg_addr_in(ireg_addr_in), .ireg_data_in(ireg_data_in),
    .ireg_addr_out_1(ireg_addr_out_1), .ireg_addr_out_2(ireg_addr_out_2),
    .ireg_addr_out_3(ireg_addr_out_3), .ireg_addr_out_4(ireg_addr_out_4),
    .ireg_data_out_1(ireg_data_out_1), .ireg_data_out_2(ireg_data_out_2),
    .ireg_data_out_3(ireg_data_out_3), .ireg_data_out_4(ireg_data_out_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_bytes(input bit gaps, input int n);
    int t;
    for (int b = 0; b < n; b++) begin
      if (gaps && (b % 3 == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[b];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("load_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Collects n results; expected value is e+1 (identity test) or a constant.
  task automatic collect(input int n, input int stall_e, input bit use_const, input logic [17:0] exp_const);
    int t;
    logic [17:0] exp_v;
    for (int e = 0; e < n; e++) begin
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("out_valid", {31'd0, out_valid}, 32'd1);
      if (e == 0) first_valid_cyc = cyc;
      exp_v = use_const ? exp_const : 18'(e + 1);
      $display("[TB] elem idx=%0d data=%0d", out_idx, out_data);
      check("out_idx", {28'd0, out_idx}, 32'(e));
      check("out_data", {14'd0, out_data}, {14'd0, exp_v});
      if (e == stall_e) begin
        for (int s = 0; s < 5; s++) begin
          start = (s == 1);
          @(negedge clk);
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_idx", {28'd0, out_idx}, 32'(e));
          check("hold_data", {14'd0, out_data}, {14'd0, exp_v});
        end
        start = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic check_done();
    check("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_low", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {14'd0, out_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity x B, no input gaps, stall on element 3.
    for (int b = 0; b < 16; b++) bytes[b] = (b[3:2] == b[1:0]) ? 8'd1 : 8'd0;
    for (int b = 16; b < 32; b++) bytes[b] = 8'(b - 15);
    c0 = cyc;
    do_start();
    check("busy_load", {31'd0, busy}, 32'd1);
    load_bytes(1'b0, 32);
    collect(16, 3, 1'b0, 18'd0);
    check("latency", 32'(first_valid_cyc - c0), 32'd35);
    check_done();

    // Abort after 10 bytes, abort coinciding with a valid byte.
    for (int b = 0; b < 32; b++) bytes[b] = 8'd7;
    do_start();
    load_bytes(1'b0, 10);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    check("abort_no_write", {31'd0, ireg_write}, 32'd0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

`ifdef MM_CTRL_SIGNED_EN
    for (int b = 0; b < 32; b++) bytes[b] = 8'h80;
    do_start();
    load_bytes(1'b1, 32);
    collect(16, -1, 1'b1, 18'd65536);
    check_done();
    for (int b = 0; b < 32; b++) bytes[b] = (b < 16) ? 8'h80 : 8'h7F;
    do_start();
    load_bytes(1'b1, 32);
    collect(16, -1, 1'b1, 18'(-65024));
    check_done();
`else
    for (int b = 0; b < 32; b++) bytes[b] = 8'hFF;
    do_start();
    load_bytes(1'b1, 32);
    collect(16, -1, 1'b1, 18'd260100);
    check_done();
`endif

    // Asynchronous reset mid-COMPUTE (element 5 in flight, out_data/out_idx non-zero).
    for (int b = 0; b < 16; b++) bytes[b] = (b[3:2] == b[1:0]) ? 8'd1 : 8'd0;
    for (int b = 16; b < 32; b++) bytes[b] = 8'(b - 15);
    do_start();
    load_bytes(1'b0, 32);
    collect(5, -1, 1'b0, 18'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_data", {14'd0, out_data}, 32'd0);
    check("arst_out_idx", {28'd0, out_idx}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_write", {31'd0, ireg_write}, 32'd0);
    check("arst_raddr", {27'd0, ireg_addr_out_1}, 32'd0);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
